ex_hazard_controller: RTL and testbench
=======================================

// Module: ex_hazard_controller
// PURPOSE
//  Sequences the RV32E execute stage: computes forward_a/forward_b one stage early (registered into ID/EX),
//  detects load-use hazards, flushes on taken branch/jump, holds the pipe while a multi-cycle EX op runs.
//  Sits beside the ID/EX register; drives PC/IF-ID/ID-EX/EX-MEM enables and bubbles. Keeps perf counters.
// PARAMETERS
//  CNT_W  32  width of stall_cycles / flush_events counters (wrap modulo 2^CNT_W)
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  id_rs1_addr    in   4      rs1 of instruction in ID
//  id_rs2_addr    in   4      rs2 of instruction in ID
//  id_uses_rs1    in   1      ID instruction reads rs1
//  id_uses_rs2    in   1      ID instruction reads rs2
//  ex_rd_addr     in   4      rd of instruction in EX
//  ex_reg_write   in   1      EX instruction writes rd
//  ex_mem_read    in   1      EX instruction is a load
//  mem_rd_addr    in   4      rd of instruction in MEM
//  mem_reg_write  in   1      MEM instruction writes rd
//  ex_branch_taken in  1      taken branch/jump resolved in EX this cycle
//  ex_mc_start    in   1      EX instruction starts multi-cycle op (1-cycle pulse)
//  ex_mc_done     in   1      multi-cycle result valid this cycle
//  forward_a      out  2      registered: 00 regfile, 01 WB, 10 MEM
//  forward_b      out  2      same encoding for rs2
//  stall_pc       out  1      hold PC
//  stall_if_id    out  1      hold IF/ID
//  flush_if_id    out  1      zero IF/ID (NOP)
//  stall_id_ex    out  1      hold ID/EX
//  bubble_id_ex   out  1      load NOP into ID/EX
//  bubble_ex_mem  out  1      load NOP into EX/MEM
//  mc_busy        out  1      FSM in MC_WAIT
//  stall_cycles   out  CNT_W  cycles with stall_pc=1
//  flush_events   out  CNT_W  cycles with flush_if_id=1
// BEHAVIOUR
//  Reset: state=RUN, forward_a/b=00, counters=0; all stall/flush/bubble outputs and mc_busy=0 in reset cycle.
//  Hazard terms (x0 never matches): fwd_mem_x = ex_reg_write & ex_rd!=0 & ex_rd==id_rsx & id_uses_rsx (->10);
//   else fwd_wb_x = mem_reg_write & mem_rd!=0 & mem_rd==id_rsx & id_uses_rsx (->01); else 00.
//   Nearest producer wins. WB->ID handled by write-first regfile; not forwarded.
//  load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
//  State RUN, combinational priority:
//   1 ex_branch_taken: flush_if_id=1, bubble_id_ex=1; no stall; ex_mc_start ignored (illegal combination).
//   2 ex_mc_start: stall_pc=stall_if_id=stall_id_ex=1, bubble_ex_mem=1; next=MC_WAIT.
//   3 load_use: stall_pc=stall_if_id=1, bubble_id_ex=1 (exactly one bubble; retried next cycle as 01 fwd).
//   4 else all 0.
//  State MC_WAIT: mc_busy=1; branch_taken ignored.
//   ex_mc_done=0: stall_pc/if_id/id_ex=1, bubble_ex_mem=1, stay.
//   ex_mc_done=1: all stalls 0, bubble_ex_mem=0 (result enters EX/MEM); next=RUN. Zero-length op (done
//   with start) not supported: done is sampled only in MC_WAIT.
//  forward_a/b register (latency 1, aligned with ID/EX load): stall_id_ex -> hold; bubble_id_ex -> 00;
//   else computed terms. MC unit captures operands on its start cycle; held values unused after.
//  Counters: stall_cycles += stall_pc; flush_events += flush_if_id; every cycle, wrap silently.
//  rst during MC_WAIT: immediate return to RUN with reset values; in-flight MC op abandoned.
// STRUCTURE
//  Shared package: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; state enum RUN/MC_WAIT; REG_X0=4'd0.
//  Sub-module: hazard_compare (pure comb: rs/rd compares -> fwd code, load_use). Remainder inline.
// TESTING
//  1 ADD x5 in EX, ID reads rs1=x5 -> next cycle forward_a=10, forward_b=00, no stall.
//  2 LW x6 in EX, ID rs2=x6 -> stall_pc=stall_if_id=bubble_id_ex=1 one cycle, forward_b=00; then forward_b=01.
//  3 EX writes x0, ID reads x0 -> forward_a=00, no load_use stall even if ex_mem_read=1.
//  4 branch_taken with load_use same cycle -> flush_if_id=bubble_id_ex=1, stall_pc=0, flush_events+1.
//  5 mc_start, done after 4 cycles -> mc_busy 4 cycles, stall_cycles+4, forward regs held, RUN after done.
//  6 rst asserted 2nd cycle of MC_WAIT -> next cycle RUN, mc_busy=0, counters=0, forward_a/b=00.

Source files
------------

// File: rtl/ex_hazard_controller_pkg.sv
// Shared encodings for the RV32E execute-stage hazard controller.
// Forwarding codes, FSM state type and the operand-forward selection rule.
package ex_hazard_controller_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [3:0] REG_X0 = 4'd0;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hz_state_e;

    // Nearest producer wins: EX result beats MEM result; x0 never matches.
    function automatic logic [1:0] fwd_select(
        input logic [3:0] rs,
        input logic       uses_rs,
        input logic [3:0] ex_rd,
        input logic       ex_reg_write,
        input logic [3:0] mem_rd,
        input logic       mem_reg_write
    );
        if (uses_rs && ex_reg_write && (ex_rd != REG_X0) && (ex_rd == rs))
            return FWD_MEM;
        else if (uses_rs && mem_reg_write && (mem_rd != REG_X0) && (mem_rd == rs))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/ex_hazard_controller_hazard_compare.sv
// Pure combinational register-address comparison: forward codes for both
// source operands of the ID instruction and the load-use hazard flag.
module hazard_compare
    import ex_hazard_controller_pkg::*;
(
    input  logic [3:0] id_rs1_addr,
    input  logic [3:0] id_rs2_addr,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [3:0] ex_rd_addr,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [3:0] mem_rd_addr,
    input  logic       mem_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        fwd_a = fwd_select(id_rs1_addr, id_uses_rs1, ex_rd_addr, ex_reg_write,
                           mem_rd_addr, mem_reg_write);
        fwd_b = fwd_select(id_rs2_addr, id_uses_rs2, ex_rd_addr, ex_reg_write,
                           mem_rd_addr, mem_reg_write);

        rs1_hit  = id_uses_rs1 && (ex_rd_addr == id_rs1_addr);
        rs2_hit  = id_uses_rs2 && (ex_rd_addr == id_rs2_addr);
        load_use = ex_mem_read && (ex_rd_addr != REG_X0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/ex_hazard_controller.sv
// RV32E execute-stage hazard controller: forwarding select registers, load-use
// stall, branch flush, multi-cycle EX hold FSM and stall/flush perf counters.
module ex_hazard_controller
    import ex_hazard_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs1_addr,
    input  logic [3:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [3:0]       ex_rd_addr,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [3:0]       mem_rd_addr,
    input  logic             mem_reg_write,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             stall_id_ex,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    hz_state_e  state;
    hz_state_e  next_state;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;
    logic       load_use;

    hazard_compare u_hazard_compare (
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .fwd_a         (fwd_a_c),
        .fwd_b         (fwd_b_c),
        .load_use      (load_use)
    );

    always_comb begin
        next_state    = state;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        flush_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        mc_busy       = 1'b0;

        // Reset forces every control output low in the reset cycle itself.
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                    end else if (ex_mc_start) begin
                        stall_pc      = 1'b1;
                        stall_if_id   = 1'b1;
                        stall_id_ex   = 1'b1;
                        bubble_ex_mem = 1'b1;
                        next_state    = MC_WAIT;
                    end else if (load_use) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                    end
                end
                MC_WAIT: begin
                    mc_busy = 1'b1;
                    if (ex_mc_done) begin
                        next_state = RUN;
                    end else begin
                        stall_pc      = 1'b1;
                        stall_if_id   = 1'b1;
                        stall_id_ex   = 1'b1;
                        bubble_ex_mem = 1'b1;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            forward_a    <= FWD_NONE;
            forward_b    <= FWD_NONE;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state <= next_state;
            if (!stall_id_ex) begin
                forward_a <= bubble_id_ex ? FWD_NONE : fwd_a_c;
                forward_b <= bubble_id_ex ? FWD_NONE : fwd_b_c;
            end
            stall_cycles <= stall_cycles + CNT_W'(stall_pc);
            flush_events <= flush_events + CNT_W'(flush_if_id);
        end
    end

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed, table-driven bench for ex_hazard_controller plus hand-written
// multi-cycle and reset-during-MC_WAIT sequences.
module tb_ex_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read, mem_reg_write;
    logic        ex_branch_taken, ex_mc_start, ex_mc_done;
    logic [1:0]  forward_a, forward_b;
    logic        stall_pc, stall_if_id, flush_if_id, stall_id_ex, bubble_id_ex, bubble_ex_mem;
    logic        mc_busy;
    logic [31:0] stall_cycles, flush_events;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;

    always #5 clk = ~clk;

    ex_hazard_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .stall_id_ex(stall_id_ex), .bubble_id_ex(bubble_id_ex), .bubble_ex_mem(bubble_ex_mem),
        .mc_busy(mc_busy), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    // flags order: {stall_pc, stall_if_id, flush_if_id, stall_id_ex, bubble_id_ex, bubble_ex_mem}
    typedef struct {
        logic [3:0] rs1, rs2;
        logic       u1, u2;
        logic [3:0] ex_rd;
        logic       ex_w, ex_ld;
        logic [3:0] mem_rd;
        logic       mem_w, br;
        logic [1:0] exp_fa, exp_fb;
        logic [5:0] exp_flags;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [5:0] flags();
        return {stall_pc, stall_if_id, flush_if_id, stall_id_ex, bubble_id_ex, bubble_ex_mem};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic mcs, input logic mcd);
        id_rs1_addr     = v.rs1;
        id_rs2_addr     = v.rs2;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        ex_rd_addr      = v.ex_rd;
        ex_reg_write    = v.ex_w;
        ex_mem_read     = v.ex_ld;
        mem_rd_addr     = v.mem_rd;
        mem_reg_write   = v.mem_w;
        ex_branch_taken = v.br;
        ex_mc_start     = mcs;
        ex_mc_done      = mcd;
    endtask

    task automatic track(input logic [5:0] f);
        exp_stall += int'(f[5]);
        exp_flush += int'(f[3]);
    endtask

    vec_t idle, fwd_wb_a, add_x5;

    initial begin
        //           rs1   rs2  u1 u2 ex_rd w  ld mem_rd w br  fa     fb     flags
        vecs[0]  = '{4'd5, 4'd3, 1, 1, 4'd5,  1, 0, 4'd0,  0, 0, 2'b10, 2'b00, 6'b000000};
        vecs[1]  = '{4'd1, 4'd6, 1, 1, 4'd6,  1, 1, 4'd0,  0, 0, 2'b00, 2'b00, 6'b110010};
        vecs[2]  = '{4'd1, 4'd6, 1, 1, 4'd0,  0, 0, 4'd6,  1, 0, 2'b00, 2'b01, 6'b000000};
        vecs[3]  = '{4'd0, 4'd0, 1, 1, 4'd0,  1, 1, 4'd0,  1, 0, 2'b00, 2'b00, 6'b000000};
        vecs[4]  = '{4'd7, 4'd2, 1, 1, 4'd7,  1, 1, 4'd0,  0, 1, 2'b00, 2'b00, 6'b001010};
        vecs[5]  = '{4'd9, 4'd9, 1, 1, 4'd9,  1, 0, 4'd9,  1, 0, 2'b10, 2'b10, 6'b000000};
        vecs[6]  = '{4'd4, 4'd2, 1, 1, 4'd2,  0, 0, 4'd4,  1, 0, 2'b01, 2'b00, 6'b000000};
        vecs[7]  = '{4'd5, 4'd3, 0, 1, 4'd5,  1, 0, 4'd5,  1, 0, 2'b00, 2'b00, 6'b000000};
        vecs[8]  = '{4'd8, 4'd1, 0, 1, 4'd8,  1, 1, 4'd0,  0, 0, 2'b00, 2'b00, 6'b000000};
        vecs[9]  = '{4'd5, 4'd5, 1, 1, 4'd5,  1, 0, 4'd0,  0, 1, 2'b00, 2'b00, 6'b001010};
        vecs[10] = '{4'd3, 4'd8, 0, 1, 4'd8,  1, 1, 4'd8,  1, 0, 2'b00, 2'b00, 6'b110010};
        vecs[11] = '{4'd3, 4'd10, 1, 1, 4'd11, 1, 0, 4'd10, 1, 0, 2'b00, 2'b01, 6'b000000};

        idle     = '{4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 2'b00, 2'b00, 6'b000000};
        fwd_wb_a = '{4'd4, 4'd0, 1, 0, 4'd0, 0, 0, 4'd4, 1, 0, 2'b01, 2'b00, 6'b000000};
        add_x5   = vecs[0];

        // Reset: outputs forced low during reset, registers cleared after.
        rst = 1'b1;
        drive(vecs[4], 1'b1, 1'b0);
        #1;
        chk("reset_flags", 32'(flags()), 32'd0);
        chk("reset_mc_busy", 32'(mc_busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        drive(idle, 1'b0, 1'b0);
        #1;
        chk("reset_fwd_a", 32'(forward_a), 32'd0);
        chk("reset_fwd_b", 32'(forward_b), 32'd0);
        chk("reset_stall_cnt", stall_cycles, 32'd0);
        chk("reset_flush_cnt", flush_events, 32'd0);
        @(posedge clk); #1;

        // Table of single-cycle RUN-state vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i], 1'b0, 1'b0);
            #1;
            chk($sformatf("v%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
            chk($sformatf("v%0d_mc_busy", i), 32'(mc_busy), 32'd0);
            track(vecs[i].exp_flags);
            @(posedge clk); #1;
            chk($sformatf("v%0d_fwd_a", i), 32'(forward_a), 32'(vecs[i].exp_fa));
            chk($sformatf("v%0d_fwd_b", i), 32'(forward_b), 32'(vecs[i].exp_fb));
        end
        chk("tbl_stall_cnt", stall_cycles, exp_stall);
        chk("tbl_flush_cnt", flush_events, exp_flush);

        // Multi-cycle op: start, three waiting cycles, done on the fourth.
        @(negedge clk);
        drive(add_x5, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("mc_pre_fwd_a", 32'(forward_a), 32'b10);
        @(negedge clk);
        drive(fwd_wb_a, 1'b1, 1'b0);
        #1;
        chk("mc_start_flags", 32'(flags()), 32'b110101);
        chk("mc_start_busy", 32'(mc_busy), 32'd0);
        track(6'b110101);
        @(posedge clk); #1;
        chk("mc_start_fwd_hold", 32'(forward_a), 32'b10);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(fwd_wb_a, 1'b0, 1'b0);
            ex_branch_taken = (c == 1);
            #1;
            chk($sformatf("mc_wait%0d_flags", c), 32'(flags()), 32'b110101);
            chk($sformatf("mc_wait%0d_busy", c), 32'(mc_busy), 32'd1);
            track(6'b110101);
            @(posedge clk); #1;
            chk($sformatf("mc_wait%0d_fwd_hold", c), 32'(forward_a), 32'b10);
        end
        @(negedge clk);
        drive(fwd_wb_a, 1'b0, 1'b1);
        #1;
        chk("mc_done_flags", 32'(flags()), 32'd0);
        chk("mc_done_busy", 32'(mc_busy), 32'd1);
        @(posedge clk); #1;
        chk("mc_done_fwd_a", 32'(forward_a), 32'b01);
        chk("mc_after_busy", 32'(mc_busy), 32'd0);
        chk("mc_stall_cnt", stall_cycles, exp_stall);
        chk("mc_flush_cnt", flush_events, exp_flush);
        @(negedge clk);
        drive(idle, 1'b0, 1'b0);
        #1;
        chk("mc_back_run_flags", 32'(flags()), 32'd0);
        @(posedge clk); #1;

        // Reset on the second MC_WAIT cycle abandons the op.
        @(negedge clk);
        drive(add_x5, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        drive(idle, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        drive(idle, 1'b0, 1'b0);
        #1;
        chk("rstmc_wait1_busy", 32'(mc_busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmc_flags", 32'(flags()), 32'd0);
        chk("rstmc_busy_in_rst", 32'(mc_busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmc_busy", 32'(mc_busy), 32'd0);
        chk("rstmc_run_flags", 32'(flags()), 32'd0);
        chk("rstmc_fwd_a", 32'(forward_a), 32'd0);
        chk("rstmc_fwd_b", 32'(forward_b), 32'd0);
        chk("rstmc_stall_cnt", stall_cycles, 32'd0);
        chk("rstmc_flush_cnt", flush_events, 32'd0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
